// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - circular instruction FIFO between fetch and decode
// First-word fall-through; flush empties the queue in one cycle.
module inst_queue #(
  parameter int DEPTH    = 16,
  parameter int PTR_W    = 4,
  parameter int INS_LEN  = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  input  logic                flush,
  input  logic                push_valid,
  input  logic [INS_LEN-1:0]  push_inst,
  input  logic [ADDR_LEN-1:0] push_pc,
  output logic                full,
  input  logic                pop_ready,
  output logic                out_valid,
  output logic [INS_LEN-1:0]  out_inst,
  output logic [ADDR_LEN-1:0] out_pc,
  output logic [PTR_W:0]      count,
  output logic                overflow
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [INS_LEN-1:0]  inst_mem [DEPTH];
  logic [ADDR_LEN-1:0] pc_mem   [DEPTH];
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [PTR_W:0]      cnt;
  logic                empty;
  logic                en;
  logic                push;
  logic                pop;

  assign en        = rdy & ~flush;
  assign empty     = (cnt == '0);
  assign full      = (cnt == FULL_CNT);
  assign count     = cnt;
  assign out_valid = rdy & ~empty;
  // An empty queue presents all-zero, which decode treats as a NOP.
  assign out_inst  = empty ? '0 : inst_mem[head];
  assign out_pc    = empty ? '0 : pc_mem[head];

  assign pop  = en & out_valid & pop_ready;
  assign push = en & push_valid & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        head <= '0;
        tail <= '0;
        cnt  <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        if (push & ~pop)      cnt <= cnt + 1'b1;
        else if (pop & ~push) cnt <= cnt - 1'b1;
        if (push_valid & ~push) overflow <= 1'b1;
      end
    end
  end

  // Entry storage carries no reset; cnt alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[tail] <= push_inst;
      pc_mem[tail]   <= push_pc;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - scoreboard bench for inst_queue
// Stimulus updates a queue model; a negedge monitor compares every cycle.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst_n, rdy, flush, push_valid, pop_ready;
  logic [31:0] push_inst, push_pc;
  logic        full, out_valid, overflow;
  logic [31:0] out_inst, out_pc;
  logic [4:0]  count;

  logic [63:0] exp_q[$];
  logic        exp_ovf;
  int          n_vec = 0;
  int          n_bad = 0;

  inst_queue #(.DEPTH(16), .PTR_W(4), .INS_LEN(32), .ADDR_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .push_valid(push_valid), .push_inst(push_inst), .push_pc(push_pc),
    .full(full), .pop_ready(pop_ready), .out_valid(out_valid),
    .out_inst(out_inst), .out_pc(out_pc), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // Monitor: compares the presented head and flags, then retires a popped entry.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("full", 64'(full), 64'(exp_q.size() == 16));
      chk("out_valid", 64'(out_valid), 64'(rdy && exp_q.size() != 0));
      chk("overflow", 64'(overflow), 64'(exp_ovf));
      if (exp_q.size() != 0) begin
        chk("out_inst", 64'(out_inst), 64'(exp_q[0][63:32]));
        chk("out_pc", 64'(out_pc), 64'(exp_q[0][31:0]));
        if (rdy && !flush && pop_ready) void'(exp_q.pop_front());
      end else begin
        chk("out_inst_nop", 64'(out_inst), 64'd0);
        chk("out_pc_zero", 64'(out_pc), 64'd0);
      end
    end
  end

  // One clock of stimulus; the model is updated after the edge.
  task automatic cyc(input logic r, input logic f, input logic pv, input logic pr,
                     input logic [31:0] ins, input logic [31:0] p);
    bit do_pop, do_push, drop;
    rdy = r; flush = f; push_valid = pv; pop_ready = pr;
    push_inst = ins; push_pc = p;
    do_pop  = r && !f && pr && exp_q.size() != 0;
    do_push = r && !f && pv && (exp_q.size() < 16 || do_pop);
    drop    = r && !f && pv && !do_push;
    @(posedge clk);
    #1;
    if (r && f) exp_q.delete();
    else if (do_push) exp_q.push_back({ins, p});
    if (drop) exp_ovf = 1'b1;
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic fill(input int n, input logic [31:0] pc0);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, $urandom, pc0 + 32'(i * 4));
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rdy = 1'b0; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    push_inst = '0; push_pc = '0; exp_ovf = 1'b0;
    #1;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_full", 64'(full), 64'd0);
    chk("reset_inst", 64'(out_inst), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Ordering
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h00500093, 32'h0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h00100113, 32'h4);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h002081B3, 32'h8);
    chk("order_count", 64'(count), 64'd3);
    chk("order_head", 64'(out_inst), 64'h00500093);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    idle();

    // Full boundary, overflow, push-through-full
    fill(16, 32'h100);
    chk("full_flag", 64'(full), 64'd1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'hDEAD0001, 32'hBAD0);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_count", 64'(count), 64'd16);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'hCAFE0017, 32'h200);
    chk("pushpop_full", 64'(count), 64'd16);
    drain();

    // Wrap-around under sustained push+pop
    fill(5, 32'h1000);
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, $urandom, 32'h1014 + 32'(i * 4));
    chk("wrap_count", 64'(count), 64'd5);
    drain();

    // Flush with concurrent push and pop
    fill(7, 32'h2000);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0BADF00D, 32'h3000);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h12345678, 32'h4000);
    chk("post_flush_inst", 64'(out_inst), 64'h12345678);
    drain();

    // rdy stall
    fill(3, 32'h5000);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF0000, 32'h6000);
    chk("stall_count", 64'(count), 64'd3);
    chk("stall_head_pc", 64'(out_pc), 64'h5000);
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 99) < 85), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 50),
          $urandom, $urandom);

    // Asynchronous reset between edges
    drain();
    fill(9, 32'h7000);
    #2 rst_n = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    #1;
    chk("areset_count", 64'(count), 64'd0);
    chk("areset_full", 64'(full), 64'd0);
    chk("areset_valid", 64'(out_valid), 64'd0);
    chk("areset_ovf", 64'(overflow), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    fill(2, 32'h8000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
